io_pwm_led: RTL and testbench
=============================

IO_PWM_LED -- requirements
Module: io_pwm_led

Interface
REQ-001 SHALL have parameter NCH, default 3: number of LED channels, legal 1..8.
REQ-002 SHALL have parameter PWM_W, default 8: PWM resolution in bits, legal 4..12; MAX = 2^PWM_W-1.
REQ-003 SHALL have parameter BASE_ADR, default 14'h3C00: word address of offset 0 on the dma_io bus.
REQ-004 SHALL have port clk  in  1  sole clock; one clock domain; all state on the rising edge.
REQ-005 SHALL have port rst  in  1  reset; synchronous and active-high.
REQ-006 SHALL have port dma_io_we  in  1  write strobe, one cycle per write.
REQ-007 SHALL have port dma_io_wadr  in  14 [15:2]  write word address.
REQ-008 SHALL have port dma_io_wdata  in  32  write data.
REQ-009 SHALL have port dma_io_radr  in  14 [15:2]  read word address, always valid.
REQ-010 SHALL have port dma_io_rdata_in  in  32  read data from the upstream peripheral in the chain.
REQ-011 SHALL have port dma_io_rdata  out  32  chained read data.
REQ-012 SHALL have port led  out  NCH  LED drive, bit n = channel n.

Function
REQ-013 SHALL use register map at word offset from BASE_ADR: 0 CTRL (bit0 EN, bit1 INV), 1 PRESCALE [15:0], 2 STATUS (read-only, [PWM_W-1:0] = cnt), 4+n DUTY[n] ([PWM_W-1:0] duty, [17:16] MODE); other offsets are unmapped.
REQ-014 SHALL write a register when dma_io_we=1 and dma_io_wadr hits; writes to STATUS, unmapped offsets, or channels >= NCH are ignored; unused bits are dropped and read back 0.
REQ-015 SHALL sample the local read value of dma_io_radr into a register each cycle; the local value is 0 for unmapped offsets; dma_io_rdata = that register OR dma_io_rdata_in, combinational on dma_io_rdata_in (1-cycle latency for local data).
REQ-016 SHALL return the pre-write value when a read and a write target the same register in the same cycle.
REQ-017 SHALL run a 16-bit prescaler while EN=1, asserting tick for one cycle every PRESCALE+1 clocks; PRESCALE=0 gives a tick every clock.
REQ-018 SHALL advance PWM counter cnt on tick over 0..MAX-1 and wrap to 0; a wrap is the tick where cnt=MAX-1.
REQ-019 SHALL define raw channel output by MODE: 00 fixed PWM (cnt < duty); 01 breathe (cnt < br[n]); 10 on; 11 off.
REQ-020 SHALL, in breathe, keep a per-channel PWM_W-bit br[n] and direction bit dir[n] (1 = up); on each wrap step br by 1 in dir; flip dir to down when br reaches duty, and to up when br reaches 0; duty=0 holds br at 0.
REQ-021 SHALL clear br[n] to 0 and set dir[n] to up on any write to DUTY[n].
REQ-022 SHALL give duty=0 constant off and duty=MAX constant on in mode 00.
REQ-023 SHALL register led: led[n] = EN ? (raw[n] XOR INV) : 0, one clock after cnt/br change.
REQ-024 SHALL, while EN=0, hold the prescaler, cnt and all br/dir at 0 and drive led to 0 regardless of INV.
REQ-025 SHALL restart on EN 0->1 with prescaler=0 and cnt=0; the first tick occurs PRESCALE+1 clocks later.
REQ-026 SHALL apply a PRESCALE write from the next prescaler reload; the current count is not truncated.

Reset
REQ-027 SHALL, when rst=1 at a clock edge, clear CTRL, PRESCALE, all DUTY/MODE, the prescaler, cnt, all br, the read register and led to 0 and set all dir to up; rst takes priority over a same-cycle write.
REQ-028 SHALL make dma_io_rdata equal to dma_io_rdata_in while in reset and in the cycle after reset.

Verification
REQ-029 SHALL be checked with: write DUTY[0]=0x40 mode 00, PRESCALE=0, CTRL=1 -> led[0] high 64 of every 255 cycles, period 255 clocks.
REQ-030 SHALL be checked with: CTRL=3 (INV), DUTY[1] mode 10 -> led[1]=0; set CTRL=2 -> led all 0.
REQ-031 SHALL be checked with: DUTY[2]=0x03 mode 01 -> br over successive periods is 0,1,2,3,2,1,0,1; writing DUTY[2] mid-ramp restarts at 0.
REQ-032 SHALL be checked with: write 0xA5 to BASE_ADR+4 and read the same address on the next cycle with dma_io_rdata_in=0x100 -> dma_io_rdata=0x1A5 one cycle after the read address; same-cycle read gives the old value.
REQ-033 SHALL be checked with: PRESCALE=3 -> cnt steps every 4 clocks; rst asserted mid-period -> all outputs and registers 0 on the next cycle; a write in the reset cycle is lost.
REQ-034 SHALL be checked with: reads of offset 3 and offset 4+NCH -> local contribution 0; writes there leave all registers unchanged.

Source files
------------

// File: rtl/io_pwm_led.sv
// Multi-channel LED PWM driver with fixed, breathe, on and off modes per channel,
// controlled through a chained dma_io register port with a one-cycle read latency.
module io_pwm_led #(
    parameter int          NCH      = 3,
    parameter int          PWM_W    = 8,
    parameter logic [13:0] BASE_ADR = 14'h3C00
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dma_io_we,
    input  logic [13:0]      dma_io_wadr,
    input  logic [31:0]      dma_io_wdata,
    input  logic [13:0]      dma_io_radr,
    input  logic [31:0]      dma_io_rdata_in,
    output logic [31:0]      dma_io_rdata,
    output logic [NCH-1:0]   led
);

    localparam logic [13:0] OFF_CTRL     = 14'd0;
    localparam logic [13:0] OFF_PRESCALE = 14'd1;
    localparam logic [13:0] OFF_STATUS   = 14'd2;
    localparam logic [13:0] OFF_DUTY0    = 14'd4;

    localparam logic [1:0] MODE_PWM     = 2'b00;
    localparam logic [1:0] MODE_BREATHE = 2'b01;
    localparam logic [1:0] MODE_ON      = 2'b10;

    // Counter runs 0..MAX-1, so the last value is all ones except the LSB.
    localparam logic [PWM_W-1:0] CNT_LAST = {{(PWM_W-1){1'b1}}, 1'b0};

    logic [13:0]           wr_off;
    logic [13:0]           rd_off;
    logic                  en_reg;
    logic                  inv_reg;
    logic [15:0]           prescale_reg;
    logic [15:0]           period_reg;
    logic [15:0]           pre_cnt_reg;
    logic [PWM_W-1:0]      cnt_reg;
    logic                  tick;
    logic                  wrap;
    logic [NCH-1:0]        raw;
    logic [NCH-1:0][31:0]  duty_word;
    logic [31:0]           rd_local;
    logic [31:0]           rdata_reg;
    logic [NCH-1:0]        led_reg;
    logic                  unused_wdata;

    assign wr_off       = dma_io_wadr - BASE_ADR;
    assign rd_off       = dma_io_radr - BASE_ADR;
    assign unused_wdata = ^dma_io_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            en_reg       <= 1'b0;
            inv_reg      <= 1'b0;
            prescale_reg <= '0;
        end else if (dma_io_we) begin
            if (wr_off == OFF_CTRL) begin
                en_reg  <= dma_io_wdata[0];
                inv_reg <= dma_io_wdata[1];
            end
            if (wr_off == OFF_PRESCALE) begin
                prescale_reg <= dma_io_wdata[15:0];
            end
        end
    end

    // period_reg latches PRESCALE only at reload, so a new value never cuts a period short.
    assign tick = en_reg && (pre_cnt_reg == period_reg);
    assign wrap = tick && (cnt_reg == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt_reg <= '0;
            period_reg  <= '0;
            cnt_reg     <= '0;
        end else if (!en_reg) begin
            pre_cnt_reg <= '0;
            period_reg  <= prescale_reg;
            cnt_reg     <= '0;
        end else if (tick) begin
            pre_cnt_reg <= '0;
            period_reg  <= prescale_reg;
            cnt_reg     <= (cnt_reg == CNT_LAST) ? '0 : cnt_reg + 1'b1;
        end else begin
            pre_cnt_reg <= pre_cnt_reg + 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic [PWM_W-1:0] duty_reg;
            logic [PWM_W-1:0] br_reg;
            logic [PWM_W-1:0] br_up;
            logic [PWM_W-1:0] br_dn;
            logic [1:0]       mode_reg;
            logic             dir_reg;
            logic             duty_we;

            assign duty_we = dma_io_we && (wr_off == OFF_DUTY0 + 14'(gi));
            assign br_up   = br_reg + 1'b1;
            assign br_dn   = br_reg - 1'b1;

            always_ff @(posedge clk) begin
                if (rst) begin
                    duty_reg <= '0;
                    mode_reg <= '0;
                    br_reg   <= '0;
                    dir_reg  <= 1'b1;
                end else begin
                    if (duty_we) begin
                        duty_reg <= dma_io_wdata[PWM_W-1:0];
                        mode_reg <= dma_io_wdata[17:16];
                    end
                    // Ramp steps once per PWM period and restarts from 0 on any DUTY write.
                    if (!en_reg || duty_we) begin
                        br_reg  <= '0;
                        dir_reg <= 1'b1;
                    end else if (wrap && (mode_reg == MODE_BREATHE)) begin
                        if (duty_reg == '0) begin
                            br_reg  <= '0;
                            dir_reg <= 1'b1;
                        end else if (dir_reg) begin
                            br_reg <= br_up;
                            if (br_up >= duty_reg) begin
                                dir_reg <= 1'b0;
                            end
                        end else begin
                            br_reg <= br_dn;
                            if (br_dn == '0) begin
                                dir_reg <= 1'b1;
                            end
                        end
                    end
                end
            end

            assign raw[gi] = (mode_reg == MODE_PWM)     ? (cnt_reg < duty_reg) :
                             (mode_reg == MODE_BREATHE) ? (cnt_reg < br_reg)   :
                             (mode_reg == MODE_ON);

            assign duty_word[gi] = 32'(duty_reg) | {14'b0, mode_reg, 16'b0};
        end
    endgenerate

    always_comb begin
        rd_local = '0;
        case (rd_off)
            OFF_CTRL:     rd_local = {30'b0, inv_reg, en_reg};
            OFF_PRESCALE: rd_local = {16'b0, prescale_reg};
            OFF_STATUS:   rd_local = 32'(cnt_reg);
            default:      rd_local = '0;
        endcase
        for (int i = 0; i < NCH; i++) begin
            if (rd_off == OFF_DUTY0 + 14'(i)) begin
                rd_local = duty_word[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_reg <= '0;
            led_reg   <= '0;
        end else begin
            rdata_reg <= rd_local;
            led_reg   <= en_reg ? (raw ^ {NCH{inv_reg}}) : '0;
        end
    end

    // Gating with rst keeps stale local data off the chain for the whole reset window.
    assign dma_io_rdata = (rst ? 32'b0 : rdata_reg) | dma_io_rdata_in;
    assign led          = led_reg;

endmodule

// File: tb/tb_io_pwm_led.sv
// Directed self-checking bench for io_pwm_led: register map, read chaining,
// PWM duty/period, invert/enable, breathe ramp, prescaler and reset behaviour.
module tb_io_pwm_led;

    localparam int          NCH      = 3;
    localparam int          PWM_W    = 8;
    localparam logic [13:0] BASE_ADR = 14'h3C00;

    logic           clk;
    logic           rst;
    logic           dma_io_we;
    logic [13:0]    dma_io_wadr;
    logic [31:0]    dma_io_wdata;
    logic [13:0]    dma_io_radr;
    logic [31:0]    dma_io_rdata_in;
    logic [31:0]    dma_io_rdata;
    logic [NCH-1:0] led;

    int checks = 0;
    int errors = 0;

    io_pwm_led #(
        .NCH      (NCH),
        .PWM_W    (PWM_W),
        .BASE_ADR (BASE_ADR)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .dma_io_we       (dma_io_we),
        .dma_io_wadr     (dma_io_wadr),
        .dma_io_wdata    (dma_io_wdata),
        .dma_io_radr     (dma_io_radr),
        .dma_io_rdata_in (dma_io_rdata_in),
        .dma_io_rdata    (dma_io_rdata),
        .led             (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    // All tasks enter and leave on a falling edge.
    task automatic wr(input int off, input logic [31:0] data);
        dma_io_wadr  = BASE_ADR + 14'(off);
        dma_io_wdata = data;
        dma_io_we    = 1'b1;
        @(negedge clk);
        dma_io_we    = 1'b0;
    endtask

    task automatic rd(input string tag, input int off, input logic [31:0] exp);
        dma_io_radr = BASE_ADR + 14'(off);
        @(negedge clk);
        chk(tag, dma_io_rdata, exp | dma_io_rdata_in);
    endtask

    task automatic count_period(input int bit_idx, output int highs);
        highs = 0;
        for (int i = 0; i < 255; i++) begin
            @(negedge clk);
            if (led[bit_idx]) highs++;
        end
    endtask

    int h0, h1, h2, falls;
    logic prev0;
    int br_exp [8] = '{0, 1, 2, 3, 2, 1, 0, 1};

    initial begin
        rst             = 1'b1;
        dma_io_we       = 1'b0;
        dma_io_wadr     = BASE_ADR;
        dma_io_wdata    = '0;
        dma_io_radr     = BASE_ADR;
        dma_io_rdata_in = 32'h55;
        repeat (3) @(negedge clk);
        chk("reset_led", 32'(led), 32'h0);
        chk("reset_rdata_chain", dma_io_rdata, 32'h55);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_rdata_chain", dma_io_rdata, 32'h55);
        dma_io_rdata_in = '0;
        rd("reset_ctrl", 0, 32'h0);
        rd("reset_duty0", 4, 32'h0);

        // Same-cycle read returns old value; next read sees new value ORed with chain.
        dma_io_rdata_in = 32'h100;
        dma_io_radr     = BASE_ADR + 14'd4;
        dma_io_wadr     = BASE_ADR + 14'd4;
        dma_io_wdata    = 32'hA5;
        dma_io_we       = 1'b1;
        @(negedge clk);
        dma_io_we = 1'b0;
        chk("rw_same_cycle_old", dma_io_rdata, 32'h100);
        @(negedge clk);
        chk("rw_next_cycle_new", dma_io_rdata, 32'h1A5);
        dma_io_rdata_in = '0;

        wr(5, 32'hFFFF_FFFF);
        rd("duty1_unused_bits_dropped", 5, 32'h0003_00FF);

        // Unmapped / read-only offsets.
        wr(3, 32'hFFFF_FFFF);
        wr(4 + NCH, 32'hFFFF_FFFF);
        wr(2, 32'hFFFF_FFFF);
        rd("unmapped_ctrl", 0, 32'h0);
        rd("unmapped_prescale", 1, 32'h0);
        rd("unmapped_status", 2, 32'h0);
        rd("unmapped_off3", 3, 32'h0);
        rd("unmapped_off_nch", 4 + NCH, 32'h0);
        rd("unmapped_duty0", 4, 32'hA5);
        rd("unmapped_duty1", 5, 32'h0003_00FF);
        rd("unmapped_duty2", 6, 32'h0);

        // Fixed PWM: duty 0x40, MAX, 0 with PRESCALE=0.
        wr(4, 32'h40);
        wr(5, 32'hFF);
        wr(6, 32'h0);
        wr(1, 32'h0);
        wr(0, 32'h1);
        repeat (9) @(negedge clk);
        rd("pwm_status_cnt", 2, 32'd9);
        chk("pwm_led_at_cnt9", 32'(led), 32'h3);
        h0 = 0; h1 = 0; h2 = 0;
        for (int i = 0; i < 255; i++) begin
            @(negedge clk);
            if (led[0]) h0++;
            if (led[1]) h1++;
            if (led[2]) h2++;
        end
        chk("pwm_duty40_highs", 32'(h0), 32'd64);
        chk("pwm_dutymax_highs", 32'(h1), 32'd255);
        chk("pwm_duty0_highs", 32'(h2), 32'd0);
        // Two falling edges of led[0] in 510 clocks starting after cnt=10 -> period 255.
        prev0 = led[0];
        falls = 0;
        h0 = 0;
        for (int i = 0; i < 510; i++) begin
            @(negedge clk);
            if (prev0 && !led[0]) falls++;
            if (led[0]) h0++;
            prev0 = led[0];
        end
        chk("pwm_falls_510", 32'(falls), 32'd2);
        chk("pwm_highs_510", 32'(h0), 32'd128);

        // Invert with forced modes, then disable with INV still set.
        wr(0, 32'h3);
        wr(5, 32'h0002_0000);
        wr(6, 32'h0003_0000);
        repeat (2) @(negedge clk);
        chk("inv_on_off_modes", 32'(led & 3'b110), 32'h4);
        wr(0, 32'h2);
        @(negedge clk);
        chk("disabled_led_zero", 32'(led), 32'h0);
        rd("disabled_cnt_zero", 2, 32'h0);

        // Breathe ramp with duty 3.
        wr(6, 32'h0001_0003);
        wr(0, 32'h1);
        for (int p = 0; p < 8; p++) begin
            count_period(2, h2);
            chk($sformatf("breathe_period%0d", p), 32'(h2), 32'(br_exp[p]));
        end
        repeat (100) @(negedge clk);
        wr(6, 32'h0001_0003);
        repeat (154) @(negedge clk);
        count_period(2, h2);
        chk("breathe_restart_p1", 32'(h2), 32'd1);
        count_period(2, h2);
        chk("breathe_restart_p2", 32'(h2), 32'd2);

        // Prescale 3: counter steps every 4 clocks.
        wr(0, 32'h0);
        wr(1, 32'h3);
        wr(0, 32'h1);
        dma_io_radr = BASE_ADR + 14'd2;
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            chk($sformatf("prescale_cnt_j%0d", j), dma_io_rdata, 32'((j - 1) / 4));
        end

        // Reset mid-period with a concurrent write.
        rst             = 1'b1;
        dma_io_we       = 1'b1;
        dma_io_wadr     = BASE_ADR + 14'd5;
        dma_io_wdata    = 32'h77;
        dma_io_radr     = BASE_ADR + 14'd4;
        dma_io_rdata_in = 32'h1234;
        @(negedge clk);
        dma_io_we = 1'b0;
        chk("midreset_led", 32'(led), 32'h0);
        chk("midreset_rdata_chain", dma_io_rdata, 32'h1234);
        rst = 1'b0;
        @(negedge clk);
        chk("midreset_after_rdata_chain", dma_io_rdata, 32'h1234);
        dma_io_rdata_in = '0;
        rd("midreset_write_lost", 5, 32'h0);
        rd("midreset_ctrl", 0, 32'h0);
        rd("midreset_prescale", 1, 32'h0);
        rd("midreset_status", 2, 32'h0);
        rd("midreset_duty0", 4, 32'h0);
        chk("midreset_led_later", 32'(led), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
